// File: rtl/xor_pkg.sv
// Shared PRBS31 definitions for the 32-bit XOR scrambler/descrambler pair.
// The 32-step advance function is reused by the scrambler, the descrambler and the bench.
package xor_pkg;

    localparam int PRBS31_TAP_HI = 30;
    localparam int PRBS31_TAP_LO = 27;
    localparam logic [30:0] PRBS31_DEFAULT_SEED = 31'h7FFF_FFFF;

    typedef struct packed {
        logic [30:0] next_lfsr;
        logic [31:0] ks;
    } prbs31_step_t;

    // Keystream bit k comes from step k+1, so ks[0] is the first bit produced.
    function automatic prbs31_step_t prbs31_advance32(input logic [30:0] lfsr);
        prbs31_step_t r;
        logic [30:0]  s;
        logic         nb;
        s    = lfsr;
        r.ks = '0;
        for (int k = 0; k < 32; k++) begin
            nb      = s[PRBS31_TAP_HI] ^ s[PRBS31_TAP_LO];
            s       = {s[29:0], nb};
            r.ks[k] = nb;
        end
        r.next_lfsr = s;
        return r;
    endfunction

endpackage

// File: rtl/prbs31_keygen.sv
// Combinational 32-step PRBS31 unroll: produces one keystream word and the
// LFSR state that follows it.
module prbs31_keygen
    import xor_pkg::*;
(
    input  logic [30:0] lfsr,
    output logic [30:0] next_lfsr,
    output logic [31:0] ks
);

    prbs31_step_t step;

    always_comb begin
        step = prbs31_advance32(lfsr);
    end

    assign next_lfsr = step.next_lfsr;
    assign ks        = step.ks;

endmodule

// File: rtl/xor_descrambler_32.sv
// Additive PRBS31 descrambler with valid/ready on both sides and a one-entry
// registered output stage that passes through on simultaneous consume.
module xor_descrambler_32
    import xor_pkg::*;
#(
    parameter logic [30:0] SEED = PRBS31_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [30:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] word_count
);

    logic [30:0] lfsr_q, lfsr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [15:0] word_count_q, word_count_d;

    logic [30:0] lfsr_next;
    logic [31:0] ks;
    logic        accept;

    prbs31_keygen u_keygen (
        .lfsr      (lfsr_q),
        .next_lfsr (lfsr_next),
        .ks        (ks)
    );

    assign in_ready = !seed_load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Consume first, then a new accept may refill the slot in the same cycle;
    // seed_load blocks accepts but never disturbs the held output.
    always_comb begin
        lfsr_d       = lfsr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        word_count_d = word_count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (seed_load) begin
            lfsr_d       = (seed == 31'h0) ? SEED : seed;
            word_count_d = 16'h0;
        end else if (accept) begin
            lfsr_d       = lfsr_next;
            out_data_d   = in_data ^ ks;
            out_valid_d  = 1'b1;
            word_count_d = word_count_q + 16'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q       <= SEED;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h0;
            word_count_q <= 16'h0;
        end else begin
            lfsr_q       <= lfsr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_xor_descrambler_32.sv
// Self-checking bench for xor_descrambler_32: table-driven round trip plus
// hand-written backpressure, seed-load and reset sequences, scoreboard-checked.
module tb_xor_descrambler_32;
    import xor_pkg::*;

    localparam logic [30:0] TB_SEED = 31'h7FFF_FFFF;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [30:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] word_count;

    int          check_count = 0;
    int          error_count = 0;
    int          stall_count = 0;
    logic [31:0] sb[$];
    logic [30:0] model_lfsr;

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    xor_descrambler_32 #(.SEED(TB_SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference: feedback is the parity of the tapped bits.
    function automatic logic [62:0] tb_advance(input logic [30:0] s0);
        logic [30:0] s;
        logic [31:0] ks;
        logic        fb;
        s  = s0;
        ks = '0;
        for (int k = 0; k < 32; k++) begin
            fb    = ^(s & 31'h4800_0000);
            ks[k] = fb;
            s     = (s << 1) | {30'b0, fb};
        end
        return {s, ks};
    endfunction

    function automatic logic [31:0] model_exp(input logic [31:0] din);
        logic [62:0] r;
        r = tb_advance(model_lfsr);
        return din ^ r[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [31:0] din, input logic [31:0] exp);
        bit          done;
        logic [62:0] r;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = din;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (in_ready && !rst) begin
                done = 1'b1;
                sb.push_back(exp);
                r          = tb_advance(model_lfsr);
                model_lfsr = r[62:32];
            end else begin
                stall_count++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        checkOutput("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_lfsr = TB_SEED;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) checkOutput("sb_empty", 64'd1, 64'd0);
                else checkOutput("out_data", 64'(out_data), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] plain[4];
        logic [30:0] l;
        logic [62:0] r;
        logic [31:0] held;
        prbs31_step_t ps;
        logic [30:0] seeds[3];

        plain[0] = 32'hDEAD_BEEF;
        plain[1] = 32'h1234_5678;
        plain[2] = 32'hFFFF_FFFF;
        plain[3] = 32'h0000_0000;
        l = TB_SEED;
        foreach (vecs[i]) begin
            r           = tb_advance(l);
            vecs[i].din = plain[i] ^ r[31:0];
            vecs[i].exp = plain[i];
            l           = r[62:32];
        end

        rst        = 1'b1;
        seed_load  = 1'b0;
        seed       = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        model_lfsr = TB_SEED;

        seeds[0] = TB_SEED;
        seeds[1] = 31'h1;
        seeds[2] = 31'($urandom) | 31'h1;
        foreach (seeds[i]) begin
            ps = prbs31_advance32(seeds[i]);
            checkOutput("pkg_advance32", 64'(ps), 64'(tb_advance(seeds[i])));
        end

        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_word_count", 64'(word_count), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        $display("[TB] zero stream from SEED");
        stall_count = 0;
        applyStimulus(32'h0, 32'h7000_0000);
        checkOutput("latency_valid", 64'(out_valid), 64'd1);
        for (int i = 1; i < 4; i++) applyStimulus(32'h0, model_exp(32'h0));
        checkOutput("stream_stalls", 64'(stall_count), 64'd0);
        checkOutput("word_count_4", 64'(word_count), 64'd4);
        waitDrain();

        $display("[TB] round trip table");
        doReset();
        foreach (vecs[i]) applyStimulus(vecs[i].din, vecs[i].exp);
        waitDrain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(32'hCAFE_F00D, model_exp(32'hCAFE_F00D));
        held      = out_data;
        in_valid  = 1'b1;
        in_data   = 32'h0BAD_C0DE;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_data", 64'(out_data), 64'(held));
            @(negedge clk);
        end
        out_ready = 1'b1;
        applyStimulus(32'h0BAD_C0DE, model_exp(32'h0BAD_C0DE));
        applyStimulus(32'h5555_AAAA, model_exp(32'h5555_AAAA));
        waitDrain();

        $display("[TB] seed load 1");
        seed_load = 1'b1;
        seed      = 31'h1;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_5555;
        #1;
        checkOutput("seed_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        seed_load  = 1'b0;
        in_valid   = 1'b0;
        model_lfsr = 31'h1;
        checkOutput("seed_word_count", 64'(word_count), 64'd0);
        applyStimulus(32'h0, 32'h4800_0000);
        applyStimulus(32'h1357_9BDF, model_exp(32'h1357_9BDF));
        checkOutput("seed_word_count_2", 64'(word_count), 64'd2);
        waitDrain();

        $display("[TB] seed load 0");
        seed_load = 1'b1;
        seed      = 31'h0;
        @(negedge clk);
        seed_load  = 1'b0;
        model_lfsr = TB_SEED;
        applyStimulus(32'h0, 32'h7000_0000);
        applyStimulus(32'h2468_ACE0, model_exp(32'h2468_ACE0));
        waitDrain();

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(32'h7777_7777, model_exp(32'h7777_7777));
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_lfsr = TB_SEED;
        checkOutput("post_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("post_reset_count", 64'(word_count), 64'd0);
        out_ready = 1'b1;
        applyStimulus(32'h0, 32'h7000_0000);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
